// File: rtl/pc_sequencer_if.sv
// Fetch bus between the PC sequencer and instruction memory.
//   IF_REQ    : fetch request, held until granted
//   IF_ADDR   : fetch address (the architectural PC while IF_REQ=1)
//   IF_GNT    : memory accepts the request this cycle
//   IF_RVALID : instruction word valid (at least one cycle after IF_GNT)
//   IF_RDATA  : instruction word
// master = sequencer side, slave = memory side.
interface pc_sequencer_if;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_GNT;
  logic        IF_RVALID;
  logic [31:0] IF_RDATA;

  modport master (
    output IF_REQ,
    output IF_ADDR,
    input  IF_GNT,
    input  IF_RVALID,
    input  IF_RDATA
  );

  modport slave (
    input  IF_REQ,
    input  IF_ADDR,
    output IF_GNT,
    output IF_RVALID,
    output IF_RDATA
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the architectural PC, fetches one instruction at a time over the
// fetch bus, holds it for execute until retire, then selects the next PC
// (JALR > taken branch > sequential). A misaligned next PC parks the block in a sticky
// trap state that only reset clears.
// Ports:
//   CLK, RST_N      : clock, synchronous active-low reset
//   fetch_bus       : request/grant/response bus to instruction memory
//   INSTR/_VALID    : fetched instruction presented to decode/execute
//   STALL           : execute not ready to retire
//   BR_TAKEN/BR_IMM : taken branch and its sign-extended offset
//   JALR/JALR_TGT   : register-indirect jump and its target
//   HALT            : park after the current instruction retires
//   PC, PC_PLUS4    : current PC and link value
//   TRAP, TRAP_PC   : sticky misaligned-target flag and offending address
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INCR         = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  pc_sequencer_if.master         fetch_bus,
  output logic [31:0]            INSTR,
  output logic                   INSTR_VALID,
  input  logic                   STALL,
  input  logic                   BR_TAKEN,
  input  logic [31:0]            BR_IMM,
  input  logic                   JALR,
  input  logic [31:0]            JALR_TGT,
  input  logic                   HALT,
  output logic [31:0]            PC,
  output logic [31:0]            PC_PLUS4,
  output logic                   TRAP,
  output logic [31:0]            TRAP_PC
);

  localparam logic [31:0] IncrW = 32'(INCR);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StHalted,
    StTrapped
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        if_req_q, instr_valid_q, trap_q;
  logic [31:0] target;

  // Next-PC candidate, only consumed on retire.
  always_comb begin
    if (JALR) begin
      target = JALR_TGT & ~32'h1;
    end else if (BR_TAKEN) begin
      target = pc_q + BR_IMM;
    end else begin
      target = pc_q + IncrW;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    trap_pc_d = trap_pc_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (fetch_bus.IF_GNT) state_d = StWait;
      end
      StWait: begin
        if (fetch_bus.IF_RVALID) begin
          instr_d = fetch_bus.IF_RDATA;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!STALL) begin
          if (target[1:0] != 2'b00) begin
            trap_pc_d = target;
            state_d   = StTrapped;
          end else begin
            pc_d    = target;
            state_d = HALT ? StHalted : StFetch;
          end
        end
      end
      StHalted: begin
        if (!HALT) state_d = StFetch;
      end
      StTrapped: state_d = StTrapped;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0;
      trap_pc_q     <= 32'h0;
      if_req_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      trap_pc_q     <= trap_pc_d;
      // Status outputs are registered copies of the next state's decode.
      if_req_q      <= (state_d == StFetch);
      instr_valid_q <= (state_d == StExec);
      trap_q        <= (state_d == StTrapped);
    end
  end

  assign fetch_bus.IF_REQ  = if_req_q;
  assign fetch_bus.IF_ADDR = pc_q;
  assign INSTR             = instr_q;
  assign INSTR_VALID       = instr_valid_q;
  assign PC                = pc_q;
  assign PC_PLUS4          = pc_q + IncrW;
  assign TRAP              = trap_q;
  assign TRAP_PC           = trap_pc_q;

endmodule
